// File: rtl/motor_pkg.sv
// Shared definitions for the motor gate-drive path.
package motor_pkg;

    // Per-phase half-bridge state.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        HS_ON = 2'd1,
        LS_ON = 2'd2,
        DEAD  = 2'd3
    } phase_state_e;

    // Phase indices into the 3-bit gate vectors.
    localparam int PH_A = 2;
    localparam int PH_B = 1;
    localparam int PH_C = 0;
    localparam int NUM_PH = 3;

    // Pattern layout: high side of A/B/C in [5:3], low side in [2:0].
    localparam int PAT_HS_LSB = 3;
    localparam int PAT_LS_LSB = 0;

    // Decoded switch request of one phase.
    typedef struct packed {
        logic hs;
        logic ls;
    } phase_req_t;

endpackage

// File: rtl/dt_phase.sv
// One half-bridge: OFF/HS_ON/LS_ON/DEAD FSM with dead-time counter.
module dt_phase
    import motor_pkg::*;
#(
    parameter int K_DT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              req_hs,
    input  logic              req_ls,
    input  logic [K_DT_W-1:0] i_deadtime,
    output logic              gate_hs,
    output logic              gate_ls,
    output logic              in_dead,
    output logic              st_req
);

    phase_state_e      state;
    logic [K_DT_W-1:0] cnt;
    logic              want_hs;
    logic              want_ls;
    logic [K_DT_W-1:0] dt_load;

    // Shoot-through requests degrade to OFF; the top reports them.
    assign st_req  = req_hs & req_ls;
    assign want_hs = req_hs & ~req_ls;
    assign want_ls = req_ls & ~req_hs;
    assign in_dead = (state == DEAD);
    // A programmed dead time of 0 still gives one dead cycle.
    assign dt_load = (i_deadtime == '0) ? '0 : i_deadtime - 1'b1;

    // Phase FSM; gates are registered alongside the state they decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= OFF;
            cnt     <= '0;
            gate_hs <= 1'b0;
            gate_ls <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (want_hs) begin
                        state   <= HS_ON;
                        gate_hs <= 1'b1;
                    end else if (want_ls) begin
                        state   <= LS_ON;
                        gate_ls <= 1'b1;
                    end
                end
                HS_ON: begin
                    if (!want_hs) begin
                        state   <= DEAD;
                        cnt     <= dt_load;
                        gate_hs <= 1'b0;
                    end
                end
                LS_ON: begin
                    if (!want_ls) begin
                        state   <= DEAD;
                        cnt     <= dt_load;
                        gate_ls <= 1'b0;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (want_hs) begin
                        state   <= HS_ON;
                        gate_hs <= 1'b1;
                    end else if (want_ls) begin
                        state   <= LS_ON;
                        gate_ls <= 1'b1;
                    end else begin
                        state <= OFF;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dead_time_inserter.sv
// Three-phase dead-time inserter: request decode, per-phase FSMs, fault flag.
module dead_time_inserter
    import motor_pkg::*;
#(
    parameter int K_DT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [K_DT_W-1:0] i_deadtime,
    input  logic [5:0]        i_pattern,
    input  logic              i_fault_clr,
    output logic [2:0]        o_gate_hs,
    output logic [2:0]        o_gate_ls,
    output logic              o_busy,
    output logic              o_fault
);

    phase_req_t [NUM_PH-1:0] req;
    logic       [NUM_PH-1:0] in_dead;
    logic       [NUM_PH-1:0] st_req;

    for (genvar k = 0; k < NUM_PH; k++) begin : g_ph
        assign req[k].hs = i_enable & i_pattern[PAT_HS_LSB + k];
        assign req[k].ls = i_enable & i_pattern[PAT_LS_LSB + k];

        dt_phase #(.K_DT_W(K_DT_W)) u_phase (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .req_hs     (req[k].hs),
            .req_ls     (req[k].ls),
            .i_deadtime (i_deadtime),
            .gate_hs    (o_gate_hs[k]),
            .gate_ls    (o_gate_ls[k]),
            .in_dead    (in_dead[k]),
            .st_req     (st_req[k])
        );
    end

    assign o_busy = |in_dead;

    // Sticky fault flag; a new shoot-through beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fault <= 1'b0;
        end else if (|st_req) begin
            o_fault <= 1'b1;
        end else if (i_fault_clr) begin
            o_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dead_time_inserter.sv
// Directed bench for dead_time_inserter plus a randomized overlap sweep.
module tb_dead_time_inserter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] dt;
    logic [5:0] pat;
    logic       fclr;
    logic [2:0] hs;
    logic [2:0] ls;
    logic       busy;
    logic       fault;

    int n_chk = 0;
    int n_err = 0;

    dead_time_inserter #(.K_DT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_deadtime  (dt),
        .i_pattern   (pat),
        .i_fault_clr (fclr),
        .o_gate_hs   (hs),
        .o_gate_ls   (ls),
        .o_busy      (busy),
        .o_fault     (fault)
    );

    always #5 clk = ~clk;

    // Gates of one phase must never overlap.
    always @(negedge clk) begin
        assert ((hs & ls) == 3'b000) else $error("overlap hs=%b ls=%b", hs, ls);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        rst = 1'b1; en = 1'b0; dt = 8'd4; pat = 6'b0; fclr = 1'b0;
        step(); step();
        chk("rst_hs", {29'd0, hs}, 0);
        chk("rst_ls", {29'd0, ls}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_fault", {31'd0, fault}, 0);
        rst = 1'b0;

        // Basic on: A high, B low.
        en = 1'b1; dt = 8'd4; pat = 6'b100010;
        step();
        chk("on_hs", {29'd0, hs}, 32'b100);
        chk("on_ls", {29'd0, ls}, 32'b010);
        chk("on_busy", {31'd0, busy}, 0);
        chk("on_fault", {31'd0, fault}, 0);

        // Side swap on A with 4 dead cycles.
        pat = 6'b000110;
        step();
        chk("sw_off_hs", {29'd0, hs}, 0);
        chk("sw_off_ls", {29'd0, ls}, 32'b010);
        chk("sw_busy0", {31'd0, busy}, 1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("sw_dead_hs", {29'd0, hs}, 0);
            chk("sw_dead_ls", {29'd0, ls}, 32'b010);
            chk("sw_dead_busy", {31'd0, busy}, 1);
        end
        step();
        chk("sw_on_ls", {29'd0, ls}, 32'b110);
        chk("sw_on_hs", {29'd0, hs}, 0);
        chk("sw_on_busy", {31'd0, busy}, 0);

        // Dead time 0 behaves as 1, both directions.
        dt = 8'd0; pat = 6'b100010;
        step();
        chk("z1_busy", {31'd0, busy}, 1);
        chk("z1_hs", {29'd0, hs}, 0);
        step();
        chk("z1_on", {29'd0, hs}, 32'b100);
        chk("z1_busyoff", {31'd0, busy}, 0);
        pat = 6'b000110;
        step();
        chk("z2_busy", {31'd0, busy}, 1);
        chk("z2_ls", {29'd0, ls}, 32'b010);
        step();
        chk("z2_on", {29'd0, ls}, 32'b110);

        // Reach HS on A quickly, then bounce during a 6-cycle dead time.
        dt = 8'd1; pat = 6'b100010;
        step(); step();
        chk("bn_pre", {29'd0, hs}, 32'b100);
        dt = 8'd6; pat = 6'b000110;
        step();
        chk("bn_d1", {31'd0, busy}, 1);
        pat = 6'b100010;
        dt = 8'd2;  // must not shorten the running count
        step();
        chk("bn_d2", {31'd0, busy}, 1);
        for (int i = 3; i <= 6; i++) begin
            step();
            chk("bn_dead_hs", {29'd0, hs}, 0);
            chk("bn_dead_busy", {31'd0, busy}, 1);
        end
        step();
        chk("bn_back", {29'd0, hs}, 32'b100);
        chk("bn_idle", {31'd0, busy}, 0);

        // Shoot-through on A.
        dt = 8'd2; pat = 6'b100100;
        step();
        chk("st_hs", {29'd0, hs}, 0);
        chk("st_ls", {29'd0, ls}, 0);
        chk("st_fault", {31'd0, fault}, 1);
        chk("st_busy", {31'd0, busy}, 1);
        pat = 6'b000000;
        step();
        chk("st_busy2", {31'd0, busy}, 1);
        chk("st_sticky", {31'd0, fault}, 1);
        step();
        chk("st_off", {31'd0, busy}, 0);
        chk("st_off_hs", {29'd0, hs}, 0);
        chk("st_sticky2", {31'd0, fault}, 1);
        fclr = 1'b1;
        step();
        chk("st_clr", {31'd0, fault}, 0);
        pat = 6'b100100;
        step();
        chk("st_setwins", {31'd0, fault}, 1);
        pat = 6'b000000;
        step();
        chk("st_clr2", {31'd0, fault}, 0);
        fclr = 1'b0;

        // Brake pattern, then disable.
        dt = 8'd3; pat = 6'b000111;
        step();
        chk("br_ls", {29'd0, ls}, 32'b111);
        en = 1'b0;
        step();
        chk("dis_hs", {29'd0, hs}, 0);
        chk("dis_ls", {29'd0, ls}, 0);
        chk("dis_b1", {31'd0, busy}, 1);
        step();
        chk("dis_b2", {31'd0, busy}, 1);
        step();
        chk("dis_b3", {31'd0, busy}, 1);
        step();
        chk("dis_idle", {31'd0, busy}, 0);

        // Reset in the middle of a long dead time.
        en = 1'b1; pat = 6'b000111;
        step();
        chk("rm_ls", {29'd0, ls}, 32'b111);
        dt = 8'd10; pat = 6'b111000;
        step();
        chk("rm_dead", {31'd0, busy}, 1);
        step();
        rst = 1'b1;
        step();
        chk("rm_hs", {29'd0, hs}, 0);
        chk("rm_ls0", {29'd0, ls}, 0);
        chk("rm_busy", {31'd0, busy}, 0);
        rst = 1'b0; pat = 6'b000000;
        acc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            acc = acc | (|hs) | (|ls) | busy;
        end
        chk("rm_norise", {31'd0, acc}, 0);

        // Random sweep; gates of a phase must never overlap.
        for (int i = 0; i < 10000; i++) begin
            pat = 6'($urandom);
            dt = 8'($urandom_range(0, 7));
            en = ($urandom_range(0, 15) != 0);
            fclr = 1'($urandom);
            step();
            chk("rnd_overlap", {29'd0, hs & ls}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
